// File: rtl/drain_out_buffer.sv
// drain_out_buffer: parallel-in, serial-out byte buffer.
// Captures NUM_BYTES bytes in one cycle, then streams them out one
// byte per accepted valid/ready transfer, element 0 first.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   buffer_clear      synchronous abort, returns to empty (no done)
//   load, load_data   block capture request and parallel bytes
//   load_ready        buffer is empty and may accept a load
//   write_enable      write_data valid toward downstream
//   write_ready       downstream accepts write_data this edge
//   write_data        current byte (0 when empty)
//   byte_index        index of current byte (0 when empty)
//   buffer_full       block loaded, nothing transferred yet
//   buffer_empty      no bytes pending
//   done              one-cycle pulse after the last transfer
module drain_out_buffer #(
    parameter int NUM_BYTES = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      buffer_clear,
    input  logic                      load,
    input  logic [NUM_BYTES-1:0][7:0] load_data,
    output logic                      load_ready,
    output logic                      write_enable,
    input  logic                      write_ready,
    output logic [7:0]                write_data,
    output logic [7:0]                byte_index,
    output logic                      buffer_full,
    output logic                      buffer_empty,
    output logic                      done
);

    localparam logic [7:0] LAST = 8'(NUM_BYTES - 1);

    typedef enum logic {
        EMPTY,
        DRAIN
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [NUM_BYTES-1:0][7:0]   data_q;
    logic [7:0]                  idx_q;
    logic                        done_q;
    logic                        xfer;
    logic                        last;

    assign xfer = (state_q == DRAIN) && write_ready;
    assign last = (idx_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || buffer_clear) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && last) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath: load is only honoured while empty; the final transfer
    // zeroes the buffer so write_data reads 0 whenever empty.
    always_ff @(posedge clk) begin
        if (rst || buffer_clear) begin
            data_q <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && last;
            if (state_q == EMPTY) begin
                if (load) begin
                    data_q <= load_data;
                    idx_q  <= '0;
                end
            end else if (xfer) begin
                if (last) begin
                    data_q <= '0;
                    idx_q  <= '0;
                end else begin
                    idx_q <= idx_q + 8'd1;
                end
            end
        end
    end

    // Byte select written as a compare-mux so the 8-bit index never
    // has to be narrowed to the array bound.
    always_comb begin
        write_data = '0;
        if (state_q == DRAIN) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (idx_q == 8'(i)) begin
                    write_data = data_q[i];
                end
            end
        end
    end

    assign write_enable = (state_q == DRAIN);
    assign buffer_empty = (state_q == EMPTY);
    assign load_ready   = buffer_empty;
    assign byte_index   = idx_q;
    // index only returns to 0 on leaving DRAIN, so index 0 in DRAIN
    // means no byte of this block has been transferred yet.
    assign buffer_full  = (state_q == DRAIN) && (idx_q == 8'd0);
    assign done         = done_q;

endmodule

// File: tb/tb_drain_out_buffer.sv
// tb_drain_out_buffer: directed self-checking bench for drain_out_buffer.
// Inputs change 1ns after each rising edge; outputs sampled there.
module tb_drain_out_buffer;

    localparam int N = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              buffer_clear = 1'b0;
    logic              load = 1'b0;
    logic [N-1:0][7:0] load_data = '0;
    logic              load_ready;
    logic              write_enable;
    logic              write_ready = 1'b0;
    logic [7:0]        write_data;
    logic [7:0]        byte_index;
    logic              buffer_full;
    logic              buffer_empty;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;

    drain_out_buffer #(.NUM_BYTES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .buffer_clear(buffer_clear),
        .load        (load),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .write_enable(write_enable),
        .write_ready (write_ready),
        .write_data  (write_data),
        .byte_index  (byte_index),
        .buffer_full (buffer_full),
        .buffer_empty(buffer_empty),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base, input logic [7:0] inc);
        for (int i = 0; i < N; i++) begin
            load_data[i] = base + 8'(i) * inc;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load = 1'b1;
        write_ready = 1'b1;
        fill(8'h77, 8'd1);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                rst = 1'b0;
                load = 1'b0;
            end
            step();
            n_tests++;
            if (buffer_empty !== 1'b1 || write_enable !== 1'b0 ||
                write_data !== 8'h00 || done !== 1'b0 ||
                load_ready !== 1'b1 || byte_index !== 8'd0 ||
                buffer_full !== 1'b0) begin
                n_fail++;
                $display("FAIL reset c=%0d: empty=%b we=%b wd=%h done=%b lr=%b idx=%0d full=%b required 1 0 00 0 1 0 0",
                         c, buffer_empty, write_enable, write_data, done,
                         load_ready, byte_index, buffer_full);
            end
        end
        write_ready = 1'b0;
    endtask

    task automatic test_stream();
        fill(8'h10, 8'd1);
        load = 1'b1;
        write_ready = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (write_enable !== 1'b1 || write_data !== 8'(8'h10 + i) ||
                byte_index !== 8'(i) || buffer_full !== (i == 0) ||
                done !== 1'b0) begin
                n_fail++;
                $display("FAIL stream i=%0d: we=%b wd=%h idx=%0d full=%b done=%b required 1 %h %0d %b 0",
                         i, write_enable, write_data, byte_index, buffer_full,
                         done, 8'(8'h10 + i), i, (i == 0));
            end
            step();
        end
        n_tests++;
        if (done !== 1'b1 || buffer_empty !== 1'b1 || write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_done: done=%b empty=%b we=%b required 1 1 0",
                     done, buffer_empty, write_enable);
        end
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_done_pulse: done=%b required 0", done);
        end
        write_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int exp_i = 0;
        int dcnt = 0;
        int cyc = 0;
        logic x;
        fill(8'hA0, 8'd1);
        load = 1'b1;
        step();
        load = 1'b0;
        while (exp_i < N && cyc < 200) begin
            write_ready = ((cyc % 3) == 0);
            n_tests++;
            if (write_enable !== 1'b1 || write_data !== 8'(8'hA0 + exp_i)) begin
                n_fail++;
                $display("FAIL backpressure cyc=%0d: we=%b wd=%h required 1 %h",
                         cyc, write_enable, write_data, 8'(8'hA0 + exp_i));
            end
            if (done === 1'b1) dcnt++;
            x = write_enable && write_ready;
            step();
            if (x) exp_i++;
            cyc++;
        end
        n_tests++;
        if (exp_i != N || done !== 1'b1 || dcnt != 0) begin
            n_fail++;
            $display("FAIL backpressure_end: bytes=%0d done=%b early_done=%0d required %0d 1 0",
                     exp_i, done, dcnt, N);
        end
        write_ready = 1'b0;
        step();
        n_tests++;
        if (done !== 1'b0 || buffer_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_pulse: done=%b empty=%b required 0 1",
                     done, buffer_empty);
        end
    endtask

    task automatic test_load_ignore();
        fill(8'h30, 8'd1);
        load = 1'b1;
        write_ready = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (write_data !== 8'(8'h30 + i) || byte_index !== 8'(i) ||
                load_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ignore i=%0d: wd=%h idx=%0d lr=%b required %h %0d 0",
                         i, write_data, byte_index, load_ready, 8'(8'h30 + i), i);
            end
            if (i == 5 || i == N - 1) begin
                fill(8'hE0, 8'd2);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;
        n_tests++;
        if (load_ready !== 1'b1 || done !== 1'b1 || write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ignore_end: lr=%b done=%b we=%b required 1 1 0",
                     load_ready, done, write_enable);
        end
        step();
        n_tests++;
        if (write_enable !== 1'b0 || buffer_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ignore_final: we=%b empty=%b required 0 1",
                     write_enable, buffer_empty);
        end
        write_ready = 1'b0;
    endtask

    task automatic test_clear();
        fill(8'h40, 8'd1);
        load = 1'b1;
        write_ready = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 7; i++) step();
        n_tests++;
        if (byte_index !== 8'd7 || write_data !== 8'h47) begin
            n_fail++;
            $display("FAIL clear_pre: idx=%0d wd=%h required 7 47",
                     byte_index, write_data);
        end
        buffer_clear = 1'b1;
        step();
        buffer_clear = 1'b0;
        write_ready = 1'b0;
        n_tests++;
        if (buffer_empty !== 1'b1 || write_enable !== 1'b0 ||
            write_data !== 8'h00 || done !== 1'b0 || byte_index !== 8'd0) begin
            n_fail++;
            $display("FAIL clear: empty=%b we=%b wd=%h done=%b idx=%0d required 1 0 00 0 0",
                     buffer_empty, write_enable, write_data, done, byte_index);
        end
        step();
        n_tests++;
        if (write_enable !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_hold: we=%b done=%b required 0 0",
                     write_enable, done);
        end
        fill(8'h55, 8'd0);
        load = 1'b1;
        write_ready = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (write_enable !== 1'b1 || write_data !== 8'h55 ||
                byte_index !== 8'(i)) begin
                n_fail++;
                $display("FAIL clear_reload i=%0d: we=%b wd=%h idx=%0d required 1 55 %0d",
                         i, write_enable, write_data, byte_index, i);
            end
            step();
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_reload_done: done=%b required 1", done);
        end
        write_ready = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        fill(8'h60, 8'd1);
        load = 1'b1;
        write_ready = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (i == N) begin
                n_tests++;
                if (done !== 1'b1 || load_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_gap: done=%b lr=%b required 1 1",
                             done, load_ready);
                end
                fill(8'hC0, 8'd1);
                load = 1'b1;
                step();
                load = 1'b0;
            end
            n_tests++;
            if (write_enable !== 1'b1 ||
                write_data !== 8'(i < N ? 8'h60 + i : 8'hC0 + i - N) ||
                buffer_full !== (i == 0 || i == N)) begin
                n_fail++;
                $display("FAIL b2b i=%0d: we=%b wd=%h full=%b required 1 %h %b",
                         i, write_enable, write_data, buffer_full,
                         8'(i < N ? 8'h60 + i : 8'hC0 + i - N),
                         (i == 0 || i == N));
            end
            step();
        end
        n_tests++;
        if (done !== 1'b1 || buffer_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b empty=%b required 1 1",
                     done, buffer_empty);
        end
        write_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_load_ignore();
        test_clear();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/drain_out_buffer.md
# drain_out_buffer

Parallel-in, serial-out byte buffer on the output side of the edge-detection datapath. It captures a block of NUM_BYTES processed pixel bytes in one cycle, then presents them one byte per accepted transfer, index 0 first, to the downstream memory-write interface using a valid/ready handshake. It is the transmit-side counterpart of the input fill buffer: that block assembles pixel bytes into a parallel buffer, and this block drains a parallel buffer back out as a byte stream.

## Interface
Parameters:
- NUM_BYTES, 12, number of bytes per block; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- buffer_clear  input  1  synchronous abort: discard contents and return to empty.
- load  input  1  request to capture load_data; accepted only when load_ready=1.
- load_data  input  NUM_BYTES x 8  unsigned pixel bytes; element 0 is sent first.
- load_ready  output  1  equals buffer_empty; an upstream block may assert load.
- write_enable  output  1  write_data is valid (the valid side of the handshake).
- write_ready  input  1  downstream accepts write_data on this edge.
- write_data  output  8  current byte; 0 when empty.
- byte_index  output  8  index of the byte currently presented; 0 when empty.
- buffer_full  output  1  a block is loaded and no byte has been transferred yet.
- buffer_empty  output  1  no bytes are pending.
- done  output  1  one-cycle pulse after the last byte of a block is transferred.

## Operation
- State machine with two states: EMPTY and DRAIN. Reset state is EMPTY.
- EMPTY:
  - write_enable=0, buffer_empty=1, load_ready=1.
  - If load=1, capture all of load_data into the internal buffer, set index=0, and go to DRAIN.
- DRAIN:
  - write_enable=1 and write_data=buffer[index], both driven combinationally from registered state.
  - A transfer occurs on an edge where write_enable=1 and write_ready=1.
  - On a transfer with index<NUM_BYTES-1: index increments by 1.
  - On a transfer with index=NUM_BYTES-1: go to EMPTY, index=0, buffer contents zeroed, done=1 for the next cycle.
  - If write_ready=0: hold index and write_data unchanged for any number of cycles.
- load is ignored in DRAIN. This includes the cycle of the final transfer, because load_ready is still 0 in that cycle.
- buffer_full=1 only in DRAIN with index=0 and no transfer completed yet for this block.
- Priority on every edge: rst > buffer_clear > handshake/load.
- buffer_clear behaves the same as rst for all state, but done is not asserted. A clear issued in the same cycle as a transfer wins, and the byte counts as not sent.
- Width rules:
  - index is an 8-bit unsigned counter and never exceeds NUM_BYTES-1.
  - There is no wrap-around past the last byte; the final transfer forces the counter back to 0.

## Timing
- Reset values (after any edge with rst=1): write_enable=0, write_data=0, byte_index=0, buffer_full=0, buffer_empty=1, load_ready=1, done=0, and all buffer bytes=0.
- Load latency: a load accepted at edge k gives write_enable=1, write_data=load_data[0], and buffer_full=1 in the cycle after edge k.
- Throughput: with write_ready held high, one byte is transferred per cycle. A block therefore drains in NUM_BYTES cycles.
- done and buffer_empty=1 appear in the cycle after the final transfer edge. A new load is accepted in that same cycle at the earliest.
- A full block cycle (load, drain, reload) takes at least NUM_BYTES+1 cycles.
- rst or buffer_clear in mid-drain: outputs reach their reset values in the cycle after that edge. No further write_enable is issued for the aborted block.

## Test plan
- Reset: hold rst for 2 cycles with load=1 and write_ready=1. Required: buffer_empty=1, write_enable=0, write_data=0, and done=0 throughout and after release.
- Streaming drain:
  - Stimulus: load bytes 0x10..0x1B, write_ready=1 constantly.
  - Required: write_data is 0x10,0x11,…,0x1B on 12 consecutive cycles, with byte_index 0..11.
  - buffer_full=1 only on the first of those cycles.
  - done=1 for exactly one cycle, after the cycle with 0x1B.
- Backpressure:
  - Stimulus: load 0xA0..0xAB, then toggle write_ready 1,0,0,1,…
  - Required: data holds during ready=0 and no byte is skipped or duplicated. The downstream sees 0xA0..0xAB in order; done=1 once.
- Load while draining:
  - Stimulus: assert load with different data at index 5, and again in the cycle of the final transfer.
  - Required: both loads are ignored. The original 12 bytes complete, then load_ready=1.
- Mid-drain clear:
  - Stimulus: assert buffer_clear at index 7, simultaneous with write_ready=1.
  - Required: the next cycle shows buffer_empty=1, write_enable=0, write_data=0, and done=0.
  - A subsequent load of 0x55 bytes then drains correctly from index 0.
- Back-to-back blocks:
  - Stimulus: assert load in the first cycle of done for a second block 0xC0..0xCB.
  - Required: the first 0xC0 appears in the following cycle and the 24 bytes are in order.
